mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/mem_wb_stage.sv | 151 +++++++++++++++
 tb/tb_mem_wb_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//
// Memory access stage fused with the MEM/WB pipeline register of a simple
// in-order MIPS-style core. Holds a private word-addressed data memory with a
// synchronous read port, so a load takes one extra cycle: the stage stalls
// the upstream pipeline for exactly one cycle while the read completes, then
// hands the loaded word to writeback.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   alu_result     byte address for loads/stores, writeback value for ALU ops
//   store_data     value to store (rt register)
//   dest_reg       destination register number
//   mem_read       instruction is a load
//   mem_to_reg     write back the loaded word instead of alu_result
//   mem_write      instruction is a store
//   reg_write      instruction writes the register file
//   jump           jump marker carried through to writeback
//   stall          combinational; upstream must hold all inputs this cycle
//   wb_data        registered writeback value
//   wb_reg         registered destination register
//   wb_regwrite    registered register-file write enable
//   wb_jump        registered jump marker
//   fwd_data       combinational forwarding value (equals alu_result)
//   misalign_err   registered one-cycle pulse after a bad memory access
// ---------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  input  logic        mem_read,
  input  logic        mem_to_reg,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        jump,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_reg,
  output logic        wb_regwrite,
  output logic        wb_jump,
  output logic [31:0] fwd_data,
  output logic        misalign_err
);

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

  state_t state;

  // Data memory is never reset; contents survive rst.
  logic [31:0] mem [2**ADDR_W];
  logic [31:0] rd_word;

  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              op_err;
  logic              load_issue;
  logic              store_go;
  logic              unused_addr_hi;

  // Only the word index bits address the memory; the remaining upper
  // address bits are intentionally ignored.
  assign word_idx       = alu_result[ADDR_W+1:2];
  assign unused_addr_hi = ^alu_result[31:ADDR_W+2];

  assign misaligned = (alu_result[1:0] != 2'b00);

  // A simultaneous read+write request is nonsensical and is reported the
  // same way as a misaligned access, whatever the address.
  assign op_err = (state == IDLE) && (mem_read || mem_write) &&
                  (misaligned || (mem_read && mem_write));

  // Loads are only issued from IDLE. In LOAD_WAIT the same inputs are still
  // being held by upstream, so this term keeps them from re-triggering.
  assign load_issue = (state == IDLE) && mem_read && !mem_write && !misaligned;
  assign store_go   = (state == IDLE) && mem_write && !mem_read && !misaligned;

  assign stall    = load_issue;
  assign fwd_data = alu_result;

  // Memory array and its synchronous read register. The read captures the
  // content present at the issue edge; stores are only ever accepted in
  // IDLE, so no write can land while a read is pending. Writes are blocked
  // while reset is held so a stale store on the bus cannot corrupt memory.
  always_ff @(posedge clk) begin
    if (store_go && !rst) begin
      mem[word_idx] <= store_data;
    end
    if (load_issue) begin
      rd_word <= mem[word_idx];
    end
  end

  // Stage controller and MEM/WB register. A bubble only clears the control
  // bits; wb_data/wb_reg keep their previous value since nothing consumes
  // them without wb_regwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wb_data      <= '0;
      wb_reg       <= '0;
      wb_regwrite  <= 1'b0;
      wb_jump      <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          misalign_err <= op_err;
          if (op_err) begin
            wb_regwrite <= 1'b0;
            wb_jump     <= 1'b0;
          end else if (load_issue) begin
            wb_regwrite <= 1'b0;
            wb_jump     <= 1'b0;
            state       <= LOAD_WAIT;
          end else begin
            wb_data     <= alu_result;
            wb_reg      <= dest_reg;
            wb_regwrite <= reg_write;
            wb_jump     <= jump;
          end
        end

        LOAD_WAIT: begin
          misalign_err <= 1'b0;
          wb_data      <= mem_to_reg ? rd_word : alu_result;
          wb_reg       <= dest_reg;
          wb_regwrite  <= reg_write;
          wb_jump      <= jump;
          state        <= IDLE;
        end

        default: begin
          misalign_err <= 1'b0;
          wb_regwrite  <= 1'b0;
          wb_jump      <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_wb_stage
//
// Directed test of mem_wb_stage. Each driven cycle pushes the MEM/WB value it
// should produce onto a scoreboard queue; one cycle later the entry is popped
// and compared with the registered outputs. Expected load data comes from a
// small memory model kept by the bench.
// ---------------------------------------------------------------------------
module tb_mem_wb_stage;

  localparam int ADDR_W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  dest_reg;
  logic        mem_read, mem_to_reg, mem_write, reg_write, jump;
  logic        stall;
  logic [31:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_regwrite, wb_jump;
  logic [31:0] fwd_data;
  logic        misalign_err;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  wreg;
    logic        regwrite;
    logic        jump;
    logic        err;
    logic        check_data;
  } wb_exp_t;

  wb_exp_t     sb_q[$];
  logic [31:0] model_mem [int];
  int          checks = 0;
  int          errors = 0;

  mem_wb_stage #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .dest_reg     (dest_reg),
    .mem_read     (mem_read),
    .mem_to_reg   (mem_to_reg),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .jump         (jump),
    .stall        (stall),
    .wb_data      (wb_data),
    .wb_reg       (wb_reg),
    .wb_regwrite  (wb_regwrite),
    .wb_jump      (wb_jump),
    .fwd_data     (fwd_data),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // Safety net so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    wb_exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      check_val({tag, " wb_regwrite"}, 32'(wb_regwrite), 32'(e.regwrite));
      check_val({tag, " wb_jump"}, 32'(wb_jump), 32'(e.jump));
      check_val({tag, " misalign_err"}, 32'(misalign_err), 32'(e.err));
      if (e.check_data) begin
        check_val({tag, " wb_data"}, wb_data, e.data);
        check_val({tag, " wb_reg"}, 32'(wb_reg), 32'(e.wreg));
      end
    end
  endtask

  // Drives one cycle of inputs, checks the combinational outputs, queues the
  // expected MEM/WB contents and checks them just after the next edge.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] sd,
                               input logic [4:0] d, input logic mr, input logic m2r,
                               input logic mw, input logic rw, input logic j,
                               input logic exp_stall, input wb_exp_t e,
                               input string tag);
    alu_result = a;
    store_data = sd;
    dest_reg   = d;
    mem_read   = mr;
    mem_to_reg = m2r;
    mem_write  = mw;
    reg_write  = rw;
    jump       = j;
    #1;
    check_val({tag, " stall"}, 32'(stall), 32'(exp_stall));
    check_val({tag, " fwd_data"}, fwd_data, a);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic do_alu(input logic [31:0] a, input logic [4:0] d, input logic rw,
                        input logic j, input string tag);
    applyStimulus(a, 32'h0, d, 1'b0, 1'b0, 1'b0, rw, j, 1'b0,
                  '{a, d, rw, j, 1'b0, 1'b1}, tag);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] sd, input string tag);
    model_mem[widx(a)] = sd;
    applyStimulus(a, sd, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                  '{a, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1}, tag);
  endtask

  // Two cycles: issue (stall, bubble) then held inputs (no stall, result).
  task automatic do_load(input logic [31:0] a, input logic [4:0] d, input logic m2r,
                         input string tag);
    logic [31:0] exp_data;
    exp_data = a;
    if (m2r) begin
      exp_data = model_mem.exists(widx(a)) ? model_mem[widx(a)] : 32'h0;
    end
    applyStimulus(a, 32'h0, d, 1'b1, m2r, 1'b0, 1'b1, 1'b0, 1'b1,
                  '{32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, {tag, " issue"});
    applyStimulus(a, 32'h0, d, 1'b1, m2r, 1'b0, 1'b1, 1'b0, 1'b0,
                  '{exp_data, d, 1'b1, 1'b0, 1'b0, 1'b1}, {tag, " wb"});
  endtask

  // Faulty access: no stall, bubble (even with reg_write/jump set), error pulse.
  task automatic do_err(input logic [31:0] a, input logic mr, input logic mw,
                        input string tag);
    applyStimulus(a, 32'h11111111, 5'd9, mr, 1'b1, mw, 1'b1, 1'b1, 1'b0,
                  '{32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0}, tag);
  endtask

  initial begin
    rst        = 1'b1;
    alu_result = '0;
    store_data = '0;
    dest_reg   = '0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    jump       = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("reset wb_data", wb_data, 32'h0);
    check_val("reset wb_reg", 32'(wb_reg), 32'h0);
    check_val("reset wb_regwrite", 32'(wb_regwrite), 32'h0);
    check_val("reset wb_jump", 32'(wb_jump), 32'h0);
    check_val("reset misalign_err", 32'(misalign_err), 32'h0);
    check_val("reset stall", 32'(stall), 32'h0);
    rst = 1'b0;

    $display("[TB] store then load");
    do_store(32'h0000_0010, 32'hDEAD_BEEF, "store 0x10");
    do_load(32'h0000_0010, 5'd8, 1'b1, "load 0x10");
    do_alu(32'h0, 5'd0, 1'b0, 1'b0, "after load idle");

    $display("[TB] alu ops");
    do_alu(32'h1234_5678, 5'd3, 1'b1, 1'b0, "alu 0x12345678");
    do_alu(32'hA5A5_0001, 5'd31, 1'b1, 1'b1, "alu jump");

    $display("[TB] misaligned and conflicting accesses");
    do_err(32'h0000_0013, 1'b1, 1'b0, "misaligned load 0x13");
    do_alu(32'h0000_0077, 5'd4, 1'b1, 1'b0, "after misaligned");
    do_store(32'h0000_0020, 32'hCAFE_F00D, "store 0x20");
    do_err(32'h0000_0020, 1'b1, 1'b1, "read+write 0x20");
    do_err(32'h0000_0022, 1'b0, 1'b1, "misaligned store 0x22");
    do_load(32'h0000_0020, 5'd12, 1'b1, "load 0x20 unchanged");
    do_load(32'h0000_0020, 5'd13, 1'b0, "load 0x20 mem_to_reg=0");

    $display("[TB] back-to-back loads");
    do_store(32'h0000_0000, 32'h0000_0001, "store 0x00");
    do_store(32'h0000_0004, 32'h0000_0002, "store 0x04");
    do_load(32'h0000_0000, 5'd5, 1'b1, "load 0x00");
    do_load(32'h0000_0004, 5'd6, 1'b1, "load 0x04");
    do_alu(32'h0, 5'd0, 1'b0, 1'b0, "after b2b idle");
    do_store(32'h0000_0410, 32'h0BAD_0BAD, "store alias 0x410");
    do_load(32'h0000_0010, 5'd7, 1'b1, "load alias 0x10");
    do_store(32'h0000_0010, 32'hDEAD_BEEF, "restore 0x10");

    $display("[TB] reset during load wait");
    do_alu(32'h1234_5678, 5'd3, 1'b1, 1'b1, "pre-reset alu");
    applyStimulus(32'h0000_0010, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                  '{32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0}, "abort load issue");
    check_val("load_wait stall", 32'(stall), 32'h0);
    rst = 1'b1;
    #1;
    check_val("mid rst wb_data", wb_data, 32'h0);
    check_val("mid rst wb_reg", 32'(wb_reg), 32'h0);
    check_val("mid rst wb_regwrite", 32'(wb_regwrite), 32'h0);
    check_val("mid rst wb_jump", 32'(wb_jump), 32'h0);
    check_val("mid rst misalign_err", 32'(misalign_err), 32'h0);
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_result = 32'h0;
    dest_reg   = 5'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_alu(32'h0, 5'd0, 1'b0, 1'b0, "post-reset idle");
    do_alu(32'h0, 5'd0, 1'b0, 1'b0, "post-reset idle 2");
    do_load(32'h0000_0010, 5'd8, 1'b1, "post-reset load 0x10");

    check_val("scoreboard drained", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
